// File: rtl/convpress_ctrl_pkg_d1.sv
`default_nettype none
// ============================================================================
// Module      : convpress_ctrl_pkg_d1
// Description : Shared state encoding and default latencies for the d1 node
//               sequencing controller.
// Revision    : 1.0
// ============================================================================
package convpress_ctrl_pkg_d1;

    localparam int DEF_ADDR_SZ  = 6;
    localparam int DEF_PIPE_LAT = 3;
    localparam int DEF_N2_LAT   = 1;
    localparam int DEF_CNT_W    = DEF_ADDR_SZ + 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_COEF  = 3'd1,
        ST_ISSUE = 3'd2,
        ST_DRAIN = 3'd3,
        ST_WRITE = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    // One extra bit so a full 2^ADDR_SZ block count is representable.
    function automatic int cnt_width(input int addr_sz);
        return addr_sz + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/convpress_vshift_d1.sv
`default_nettype none
// ============================================================================
// Module      : convpress_vshift_d1
// Description : Valid shift register tracking issued NBin reads down the node
//               pipeline; taps give the SB fetch and accumulate strobes.
// Revision    : 1.0
// ============================================================================
module convpress_vshift_d1 #(
    parameter int DEPTH = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic i_valid,
    output logic o_sb_rd,
    output logic o_acc_en
);

    logic [DEPTH-1:0] tap_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            tap_q <= '0;
        end else begin
            tap_q <= {tap_q[DEPTH-2:0], i_valid};
        end
    end

    assign o_sb_rd  = tap_q[0];
    assign o_acc_en = tap_q[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/convpress_ctrl_d1.sv
`default_nettype none
// ============================================================================
// Module      : convpress_ctrl_d1
// Description : Sequencing controller for one convpress d1 node: walks output
//               blocks, issues input blocks, schedules seed and write-back.
// Revision    : 1.0
// ============================================================================
module convpress_ctrl_d1
    import convpress_ctrl_pkg_d1::*;
#(
    parameter int ADDR_SZ  = DEF_ADDR_SZ,
    parameter int PIPE_LAT = DEF_PIPE_LAT,
    parameter int N2_LAT   = DEF_N2_LAT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_start,
    input  logic [ADDR_SZ:0]   i_num_in,
    input  logic [ADDR_SZ:0]   i_num_out,
    input  logic               i_accum,
    input  logic               i_last,
    input  logic               i_coef,
    output logic [ADDR_SZ-1:0] o_nbin_addr,
    output logic               o_nbin_ren,
    output logic               o_sb_rd,
    output logic [ADDR_SZ-1:0] o_nbout_addr,
    output logic               o_nbout_wen,
    output logic               o_n1_n2_to_nbout,
    output logic               o_load_nbout,
    output logic               o_psum_clr,
    output logic               o_acc_en,
    output logic               o_load_coef,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_err
);

    localparam int CNT_W = cnt_width(ADDR_SZ);
    // Wide enough for a cycle index within one block (K + drain).
    localparam int REL_W = $clog2((2**ADDR_SZ) + PIPE_LAT + N2_LAT + 1);

    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [REL_W-1:0] REL_ONE     = REL_W'(1);
    localparam logic [REL_W-1:0] SEED_RD_REL = REL_W'(PIPE_LAT - 2);
    localparam logic [REL_W-1:0] SEED_REL    = REL_W'(PIPE_LAT - 1);
    localparam logic [REL_W-1:0] DRAIN_N1    = REL_W'(PIPE_LAT - 2);
    localparam logic [REL_W-1:0] DRAIN_N2    = REL_W'(PIPE_LAT - 2 + N2_LAT);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   in_q, in_d;
    logic [CNT_W-1:0]   out_q, out_d;
    logic [CNT_W-1:0]   k_q, k_d;
    logic [CNT_W-1:0]   m_q, m_d;
    logic [REL_W-1:0]   drain_q, drain_d;
    logic               accum_q, accum_d;
    logic               last_q, last_d;
    logic               err_d;

    logic [REL_W-1:0]   rel_d;
    logic               run_d;
    logic               seed_rd_d;
    logic               seed_d;

    logic [ADDR_SZ-1:0] nbin_addr_q;
    logic               nbin_ren_q;
    logic [ADDR_SZ-1:0] nbout_addr_q;
    logic               nbout_wen_q;
    logic               n2_sel_q;
    logic               load_nbout_q;
    logic               psum_clr_q;
    logic               load_coef_q;
    logic               busy_q;
    logic               done_q;
    logic               err_q;

    always_comb begin
        state_d = state_q;
        in_d    = in_q;
        out_d   = out_q;
        drain_d = drain_q;
        k_d     = k_q;
        m_d     = m_q;
        accum_d = accum_q;
        last_d  = last_q;
        err_d   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    if ((i_num_in == '0) || (i_num_out == '0)) begin
                        err_d = 1'b1;
                    end else begin
                        k_d     = i_num_in;
                        m_d     = i_num_out;
                        accum_d = i_accum;
                        last_d  = i_last;
                        in_d    = '0;
                        out_d   = '0;
                        drain_d = '0;
                        state_d = i_coef ? ST_COEF : ST_ISSUE;
                    end
                end
            end
            ST_COEF: state_d = ST_ISSUE;
            ST_ISSUE: begin
                // in_q holds at K-1 after the block so the address never wraps.
                if (in_q == (k_q - CNT_ONE)) begin
                    drain_d = '0;
                    state_d = ST_DRAIN;
                end else begin
                    in_d = in_q + CNT_ONE;
                end
            end
            ST_DRAIN: begin
                if (drain_q == (last_q ? DRAIN_N2 : DRAIN_N1)) begin
                    state_d = ST_WRITE;
                end else begin
                    drain_d = drain_q + REL_ONE;
                end
            end
            ST_WRITE: begin
                if (out_q == (m_q - CNT_ONE)) begin
                    state_d = ST_DONE;
                end else begin
                    out_d   = out_q + CNT_ONE;
                    in_d    = '0;
                    state_d = ST_ISSUE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Cycle index since the block's first issue, seen in the upcoming cycle.
    always_comb begin
        rel_d = '0;
        if (state_d == ST_ISSUE) begin
            rel_d = REL_W'(in_d);
        end else if (state_d == ST_DRAIN) begin
            rel_d = REL_W'(k_d) + drain_d;
        end
        run_d     = (state_d == ST_ISSUE) || (state_d == ST_DRAIN);
        seed_rd_d = run_d && accum_d && (rel_d == SEED_RD_REL);
        seed_d    = run_d && (rel_d == SEED_REL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            in_q         <= '0;
            out_q        <= '0;
            drain_q      <= '0;
            k_q          <= '0;
            m_q          <= '0;
            accum_q      <= 1'b0;
            last_q       <= 1'b0;
            nbin_addr_q  <= '0;
            nbin_ren_q   <= 1'b0;
            nbout_addr_q <= '0;
            nbout_wen_q  <= 1'b0;
            n2_sel_q     <= 1'b0;
            load_nbout_q <= 1'b0;
            psum_clr_q   <= 1'b0;
            load_coef_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            in_q         <= in_d;
            out_q        <= out_d;
            drain_q      <= drain_d;
            k_q          <= k_d;
            m_q          <= m_d;
            accum_q      <= accum_d;
            last_q       <= last_d;
            nbin_ren_q   <= (state_d == ST_ISSUE);
            nbin_addr_q  <= (state_d == ST_ISSUE) ? in_d[ADDR_SZ-1:0] : '0;
            nbout_wen_q  <= (state_d == ST_WRITE);
            n2_sel_q     <= (state_d == ST_WRITE) && last_d;
            nbout_addr_q <= ((state_d == ST_WRITE) || seed_rd_d) ? out_d[ADDR_SZ-1:0] : '0;
            load_nbout_q <= seed_d && accum_d;
            psum_clr_q   <= seed_d && !accum_d;
            load_coef_q  <= (state_d == ST_COEF);
            busy_q       <= run_d || (state_d == ST_COEF) || (state_d == ST_WRITE);
            done_q       <= (state_d == ST_DONE);
            err_q        <= err_d;
        end
    end

    convpress_vshift_d1 #(
        .DEPTH (PIPE_LAT)
    ) u_vshift (
        .clk      (clk),
        .rst      (rst),
        .i_valid  (nbin_ren_q),
        .o_sb_rd  (o_sb_rd),
        .o_acc_en (o_acc_en)
    );

    assign o_nbin_addr      = nbin_addr_q;
    assign o_nbin_ren       = nbin_ren_q;
    assign o_nbout_addr     = nbout_addr_q;
    assign o_nbout_wen      = nbout_wen_q;
    assign o_n1_n2_to_nbout = n2_sel_q;
    assign o_load_nbout     = load_nbout_q;
    assign o_psum_clr       = psum_clr_q;
    assign o_load_coef      = load_coef_q;
    assign o_busy           = busy_q;
    assign o_done           = done_q;
    assign o_err            = err_q;

endmodule
`default_nettype wire

// File: tb/tb_convpress_ctrl_d1.sv
`default_nettype none
// ============================================================================
// Module      : tb_convpress_ctrl_d1
// Description : Self-checking bench for convpress_ctrl_d1 against a cycle
//               timeline model built from the block schedule rules.
// Revision    : 1.0
// ============================================================================
module tb_convpress_ctrl_d1;

    localparam int AW   = 6;
    localparam int PL   = 3;
    localparam int N2L  = 1;
    localparam int NCYC = 1024;

    logic          clk;
    logic          rst;
    logic          i_start;
    logic [AW:0]   i_num_in;
    logic [AW:0]   i_num_out;
    logic          i_accum;
    logic          i_last;
    logic          i_coef;
    logic [AW-1:0] o_nbin_addr;
    logic          o_nbin_ren;
    logic          o_sb_rd;
    logic [AW-1:0] o_nbout_addr;
    logic          o_nbout_wen;
    logic          o_n1_n2_to_nbout;
    logic          o_load_nbout;
    logic          o_psum_clr;
    logic          o_acc_en;
    logic          o_load_coef;
    logic          o_busy;
    logic          o_done;
    logic          o_err;

    convpress_ctrl_d1 #(
        .ADDR_SZ  (AW),
        .PIPE_LAT (PL),
        .N2_LAT   (N2L)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .i_start          (i_start),
        .i_num_in         (i_num_in),
        .i_num_out        (i_num_out),
        .i_accum          (i_accum),
        .i_last           (i_last),
        .i_coef           (i_coef),
        .o_nbin_addr      (o_nbin_addr),
        .o_nbin_ren       (o_nbin_ren),
        .o_sb_rd          (o_sb_rd),
        .o_nbout_addr     (o_nbout_addr),
        .o_nbout_wen      (o_nbout_wen),
        .o_n1_n2_to_nbout (o_n1_n2_to_nbout),
        .o_load_nbout     (o_load_nbout),
        .o_psum_clr       (o_psum_clr),
        .o_acc_en         (o_acc_en),
        .o_load_coef      (o_load_coef),
        .o_busy           (o_busy),
        .o_done           (o_done),
        .o_err            (o_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed view: {naddr[22:17], ren[16], sb[15], nbaddr[14:9], wen[8],
    //               sel[7], ld[6], clr[5], acc[4], coef[3], busy[2], done[1], err[0]}
    logic [22:0] exp_v  [NCYC];
    logic [22:0] care_v [NCYC];
    logic        rd_mark[NCYC];
    int          scn_len;
    int          total = 0;
    int          bad   = 0;

    task automatic build(input int k, input int m, input bit acc, input bit last,
                         input bit coef, input int rst_at);
        int t0;
        int w;
        int s;
        for (int c = 0; c < NCYC; c++) begin
            exp_v[c]   = '0;
            care_v[c]  = '1;
            rd_mark[c] = 1'b0;
        end
        if (k == 0 || m == 0) begin
            exp_v[1][0] = 1'b1;
            scn_len     = 4;
            return;
        end
        t0 = coef ? 2 : 1;
        w  = t0;
        if (coef) exp_v[1][3] = 1'b1;
        for (int o = 0; o < m; o++) begin
            for (int i = 0; i < k; i++) begin
                exp_v[t0+i][16]    = 1'b1;
                exp_v[t0+i][22:17] = 6'(i);
                exp_v[t0+i+1][15]  = 1'b1;
                exp_v[t0+i+PL][4]  = 1'b1;
            end
            s = t0 + PL - 1;
            if (acc) begin
                exp_v[s-1][14:9] = 6'(o);
                rd_mark[s-1]     = 1'b1;
                exp_v[s][6]      = 1'b1;
            end else begin
                exp_v[s][5] = 1'b1;
            end
            w = t0 + k + PL - 1 + (last ? N2L : 0);
            exp_v[w][8]    = 1'b1;
            exp_v[w][7]    = last;
            exp_v[w][14:9] = 6'(o);
            t0 = w + 1;
        end
        for (int c = 1; c <= w; c++) exp_v[c][2] = 1'b1;
        exp_v[w+1][1] = 1'b1;
        scn_len = w + 3;
        // Addresses are only defined while strobed, or when idle.
        for (int c = 0; c < NCYC; c++) begin
            if (exp_v[c][2] && !exp_v[c][16]) care_v[c][22:17] = '0;
            if (exp_v[c][2] && !exp_v[c][8] && !rd_mark[c]) care_v[c][14:9] = '0;
        end
        if (rst_at >= 0) begin
            for (int c = rst_at + 1; c < NCYC; c++) begin
                exp_v[c]  = '0;
                care_v[c] = '1;
            end
            scn_len = rst_at + 2;
        end
    endtask

    task automatic run_scn(input string tag, input int k, input int m, input bit acc,
                           input bit last, input bit coef, input int restart_at,
                           input int rst_at);
        logic [22:0] obs;
        build(k, m, acc, last, coef, rst_at);
        for (int c = 0; c < scn_len; c++) begin
            if (c == 0) begin
                i_start   = 1'b1;
                i_num_in  = 7'(k);
                i_num_out = 7'(m);
                i_accum   = acc;
                i_last    = last;
                i_coef    = coef;
            end else begin
                // Scrambled config mid-run must not disturb the latched one.
                i_start   = (c == restart_at);
                i_num_in  = 7'($urandom_range(1, 64));
                i_num_out = 7'($urandom_range(1, 64));
                i_accum   = 1'($urandom);
                i_last    = 1'($urandom);
                i_coef    = 1'($urandom);
            end
            rst = (c == rst_at);
            @(negedge clk);
            obs = {o_nbin_addr, o_nbin_ren, o_sb_rd, o_nbout_addr, o_nbout_wen,
                   o_n1_n2_to_nbout, o_load_nbout, o_psum_clr, o_acc_en,
                   o_load_coef, o_busy, o_done, o_err};
            total++;
            assert ((obs & care_v[c]) === (exp_v[c] & care_v[c])) else begin
                bad++;
                $error("FAIL %s cyc=%0d observed=%h expected=%h care=%h",
                       tag, c, obs & care_v[c], exp_v[c] & care_v[c], care_v[c]);
            end
            @(posedge clk);
            #1;
        end
        i_start = 1'b0;
        rst     = 1'b0;
    endtask

    initial begin
        logic [22:0] obs0;
        rst       = 1'b1;
        i_start   = 1'b0;
        i_num_in  = '0;
        i_num_out = '0;
        i_accum   = 1'b0;
        i_last    = 1'b0;
        i_coef    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        i_start = 1'b1;
        i_num_in = 7'd2;
        i_num_out = 7'd1;
        @(negedge clk);
        obs0 = {o_nbin_addr, o_nbin_ren, o_sb_rd, o_nbout_addr, o_nbout_wen,
                o_n1_n2_to_nbout, o_load_nbout, o_psum_clr, o_acc_en,
                o_load_coef, o_busy, o_done, o_err};
        total++;
        assert (obs0 === 23'd0) else begin
            bad++;
            $error("FAIL reset observed=%h expected=%h", obs0, 23'd0);
        end
        @(posedge clk);
        #1;
        i_start = 1'b0;
        rst     = 1'b0;
        @(posedge clk);
        #1;

        run_scn("k2m1",        2,  1, 1'b0, 1'b0, 1'b0, -1, -1);
        run_scn("k2m1_acc_n2", 2,  1, 1'b1, 1'b1, 1'b0, -1, -1);
        run_scn("k1m2_coef",   1,  2, 1'b0, 1'b0, 1'b1, -1, -1);
        run_scn("k0_err",      0,  1, 1'b0, 1'b0, 1'b0, -1, -1);
        run_scn("m0_err",      3,  0, 1'b1, 1'b0, 1'b0, -1, -1);
        run_scn("restart_ign", 2,  1, 1'b0, 1'b0, 1'b0,  3, -1);
        run_scn("rst_mid",     2,  1, 1'b0, 1'b0, 1'b0, -1,  4);
        run_scn("after_rst",   2,  1, 1'b0, 1'b0, 1'b0, -1, -1);
        run_scn("k64",        64,  1, 1'b0, 1'b0, 1'b0, -1, -1);
        run_scn("k64_m2_acc", 64,  2, 1'b1, 1'b1, 1'b1, -1, -1);

        for (int n = 0; n < 12; n++) begin
            run_scn("rand",
                    int'($urandom_range(1, 12)), int'($urandom_range(1, 4)),
                    1'($urandom), 1'($urandom), 1'($urandom),
                    int'($urandom_range(2, 4)), -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
